// File: rtl/restoring_div_32x32.sv
// Sequential unsigned restoring divider: one quotient bit per clock through a
// start/done handshake. Divide-by-zero completes immediately with a flag.
module restoring_div_32x32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
  // after WIDTH iterations this register holds the quotient.
  logic [WIDTH-1:0] dq_r;
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH-1:0] pr_r;
  logic [CNT_W-1:0] cnt_r;

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] pr_next_s;
  logic [WIDTH-1:0] dq_next_s;

  // One restoring step: shift in the next dividend bit and try subtracting.
  assign shifted_s = {pr_r, dq_r[WIDTH-1]};
  assign trial_s   = shifted_s - {1'b0, dsr_r};
  assign pr_next_s = trial_s[WIDTH] ? shifted_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
  assign dq_next_s = {dq_r[WIDTH-2:0], ~trial_s[WIDTH]};

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      dq_r        <= {WIDTH{1'b0}};
      dsr_r       <= {WIDTH{1'b0}};
      pr_r        <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            if (divisor == {WIDTH{1'b0}}) begin
              quotient    <= {WIDTH{1'b1}};
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state_r     <= DONE;
            end else begin
              dq_r    <= dividend;
              dsr_r   <= divisor;
              pr_r    <= {WIDTH{1'b0}};
              cnt_r   <= {CNT_W{1'b0}};
              busy    <= 1'b1;
              state_r <= RUN;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          pr_r  <= pr_next_s;
          dq_r  <= dq_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_ITER) begin
            quotient    <= dq_next_s;
            remainder   <= pr_next_s;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_div_32x32.sv
// Directed and random self-checking bench for restoring_div_32x32.
module tb_restoring_div_32x32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  restoring_div_32x32 #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive operands with start for exactly one accepting edge.
  task automatic accept(input logic [31:0] dd, input logic [31:0] ds);
    dividend = dd;
    divisor  = ds;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Called just after the accepting edge; counts edges until done is seen.
  task automatic wait_done(input logic exp_busy, input logic scramble,
                           input logic [31:0] prev_q, input logic [31:0] prev_r,
                           output int lat, output logic got, output logic ok);
    lat = 0;
    got = 1'b0;
    ok  = 1'b1;
    while (!got && lat <= 100) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy !== exp_busy) ok = 1'b0;
        if (quotient !== prev_q || remainder !== prev_r) ok = 1'b0;
        @(posedge clk);
        lat++;
        if (scramble) begin
          #1;
          dividend = $urandom;
          divisor  = $urandom;
        end
      end
    end
  endtask

  task automatic run(input string tag, input logic [31:0] dd, input logic [31:0] ds,
                     input logic [31:0] eq, input logic [31:0] er, input logic ez,
                     input int elat);
    int lat;
    logic got, ok;
    logic [31:0] pq, pr;
    pq = quotient;
    pr = remainder;
    accept(dd, ds);
    wait_done(elat != 0, 1'b0, pq, pr, lat, got, ok);
    chk({tag, ".done_seen"}, 64'(got), 64'd1);
    chk({tag, ".latency"}, 64'(lat), 64'(elat));
    chk({tag, ".run_ok"}, 64'(ok), 64'd1);
    chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, ".q"}, 64'(quotient), 64'(eq));
    chk({tag, ".r"}, 64'(remainder), 64'(er));
    chk({tag, ".dbz"}, 64'(div_by_zero), 64'(ez));
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".idle_done"}, 64'(done), 64'd0);
    chk({tag, ".idle_busy"}, 64'(busy), 64'd0);
    chk({tag, ".held_q"}, 64'(quotient), 64'(eq));
  endtask

  initial begin
    int lat;
    logic got, ok;
    logic [31:0] dd, ds;
    logic [63:0] prod;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.q", 64'(quotient), 64'd0);
    chk("reset.r", 64'(remainder), 64'd0);
    chk("reset.dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;

    run("basic_100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);
    run("max_by_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32);
    run("small_3_10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 32);
    run("msb_by_max", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 32);
    run("max_by_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32);
    run("dbz_5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
    run("after_dbz_9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 32);

    // Start held high with operands scrambled every cycle during RUN.
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    wait_done(1'b1, 1'b1, 32'd3, 32'd0, lat, got, ok);
    chk("proto.done_seen", 64'(got), 64'd1);
    chk("proto.latency", 64'(lat), 64'd32);
    chk("proto.run_ok", 64'(ok), 64'd1);
    chk("proto.q", 64'(quotient), 64'd14);
    chk("proto.r", 64'(remainder), 64'd2);
    dividend = 32'd9;
    divisor  = 32'd3;
    @(posedge clk);
    @(negedge clk);
    chk("proto.gap_busy", 64'(busy), 64'd0);
    chk("proto.gap_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("proto.reaccept_busy", 64'(busy), 64'd1);
    wait_done(1'b1, 1'b0, 32'd14, 32'd2, lat, got, ok);
    chk("proto2.latency", 64'(lat), 64'd31);
    chk("proto2.q", 64'(quotient), 64'd3);
    chk("proto2.r", 64'(remainder), 64'd0);
    @(posedge clk);
    @(negedge clk);

    // Asynchronous reset in the middle of an operation.
    run("pre_reset_100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);
    accept(32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #2;
    chk("midrst.busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.done", 64'(done), 64'd0);
    chk("midrst.q", 64'(quotient), 64'd0);
    chk("midrst.r", 64'(remainder), 64'd0);
    chk("midrst.dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run("after_rst_1000_3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 32);

    // Random operands checked against q*d + r == dividend and r < d.
    for (int n = 0; n < 1000; n++) begin
      dd = $urandom;
      ds = $urandom >> $urandom_range(0, 31);
      if (ds == 32'd0) ds = 32'd1;
      accept(dd, ds);
      wait_done(1'b1, 1'b0, quotient, remainder, lat, got, ok);
      prod = {32'd0, quotient} * {32'd0, ds} + {32'd0, remainder};
      chk("rand.identity", prod, {32'd0, dd});
      chk("rand.r_lt_d", 64'(remainder < ds), 64'd1);
      @(posedge clk);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
